// File: rtl/mod_inverse.sv
// Iterative extended-Euclid modular inverse: one quotient step per clock,
// returns a^-1 mod m and gcd(a, m) behind a start/busy/done handshake.
module mod_inverse #(
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] m,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic [WIDTH-1:0] inverse,
    output logic [WIDTH-1:0] gcd_out
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ITER = 1'b1;

    localparam logic signed [WIDTH:0] T_ONE  = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0]      R_ONE  = WIDTH'(1);

    logic [0:0]              state;
    logic [WIDTH-1:0]        r0;
    logic [WIDTH-1:0]        r1;
    logic [WIDTH-1:0]        m_reg;
    logic signed [WIDTH:0]   t0;
    logic signed [WIDTH:0]   t1;

    logic [WIDTH-1:0]        q;
    logic [WIDTH-1:0]        rem;
    logic [WIDTH-1:0]        a_mod;
    logic signed [WIDTH:0]   qt;
    logic signed [WIDTH:0]   t_next;
    logic signed [WIDTH:0]   t_fix;
    logic                    fin_valid;

    // |t| stays within m, so q*t truncated to WIDTH+1 bits is exact.
    always_comb begin
        q         = '0;
        rem       = '0;
        qt        = '0;
        t_next    = '0;
        a_mod     = '0;
        t_fix     = '0;
        fin_valid = 1'b0;
        if (r1 != '0) begin
            q = r0 / r1;
        end
        rem    = r0 - q * r1;
        qt     = $signed({1'b0, q}) * t1;
        t_next = t0 - qt;
        if (m != '0) begin
            a_mod = a % m;
        end
        fin_valid = (r0 == R_ONE) && (m_reg != '0);
        t_fix     = t0[WIDTH] ? (t0 + $signed({1'b0, m_reg})) : t0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            r0      <= '0;
            r1      <= '0;
            m_reg   <= '0;
            t0      <= '0;
            t1      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            valid   <= 1'b0;
            inverse <= '0;
            gcd_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m_reg <= m;
                        t1    <= T_ONE;
                        // m==0 degenerates to gcd(a,0)=a with no inverse.
                        if (m == '0) begin
                            r0 <= a;
                            r1 <= '0;
                            t0 <= T_ONE;
                        end else begin
                            r0 <= m;
                            r1 <= a_mod;
                            t0 <= '0;
                        end
                        busy  <= 1'b1;
                        state <= ITER;
                    end
                end
                ITER: begin
                    if (r1 != '0) begin
                        r0 <= r1;
                        r1 <= rem;
                        t0 <= t1;
                        t1 <= t_next;
                    end else begin
                        gcd_out <= r0;
                        valid   <= fin_valid;
                        inverse <= fin_valid ? t_fix[WIDTH-1:0] : '0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_inverse.sv
// Scoreboard bench for mod_inverse: directed vectors plus prime-modulus
// sweeps whose expected inverse comes from Fermat exponentiation.
module tb_mod_inverse;

    localparam int W  = 40;
    localparam int EW = 8 + 1 + 2 * W;
    localparam logic [W-1:0] M_PRIME = 40'hFF_FFFF_FFA9; // 2^40 - 87

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] m_in;
    logic         busy;
    logic         done;
    logic         valid;
    logic [W-1:0] inverse;
    logic [W-1:0] gcd_out;

    logic [EW-1:0] exp_q[$];
    int n_tests;
    int n_fail;
    int busy_cnt;

    mod_inverse #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a_in), .m(m_in),
        .busy(busy), .done(done), .valid(valid), .inverse(inverse),
        .gcd_out(gcd_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // latency 0 means only the worst-case bound is checked
    task automatic push_exp(input logic [W-1:0] inv, input logic [W-1:0] g,
                            input logic vld, input int lat);
        exp_q.push_back({8'(lat), vld, g, inv});
    endtask

    task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] m);
        @(negedge clk);
        a_in  = a;
        m_in  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle: busy still %0d after %0d cycles", busy, guard);
        end
    endtask

    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] m,
                           input logic [W-1:0] inv, input logic [W-1:0] g,
                           input logic vld, input int lat);
        push_exp(inv, g, vld, lat);
        pulse_start(a, m);
        wait_idle();
    endtask

    function automatic logic [W-1:0] modpow(input logic [W-1:0] b, input logic [W-1:0] e,
                                            input logic [W-1:0] md);
        logic [2*W-1:0] r;
        logic [2*W-1:0] x;
        logic [2*W-1:0] md2;
        md2 = {{W{1'b0}}, md};
        r   = '0;
        r[0] = 1'b1;
        x   = {{W{1'b0}}, b};
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * x) % md2;
            x = (x * x) % md2;
        end
        return r[W-1:0];
    endfunction

    // monitor: pops one expectation per done pulse
    always @(negedge clk) begin
        logic [EW-1:0] e;
        int lat;
        if (reset) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got inverse %0d gcd %0d, no result pending",
                             inverse, gcd_out);
                end else begin
                    e = exp_q.pop_front();
                    lat = int'(e[EW-1 -: 8]);
                    check("inverse", 64'(inverse), 64'(e[W-1:0]));
                    check("gcd_out", 64'(gcd_out), 64'(e[2*W-1:W]));
                    check("valid", 64'(valid), 64'(e[2*W]));
                    if (lat != 0) begin
                        check("latency", 64'(busy_cnt), 64'(lat));
                    end else begin
                        n_tests++;
                        if (busy_cnt > 60 || busy_cnt < 1) begin
                            n_fail++;
                            $display("FAIL latency_bound: got %0d expected 1..60", busy_cnt);
                        end
                    end
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        logic [W-1:0] ra;
        logic [63:0]  rnd;
        n_tests  = 0;
        n_fail   = 0;
        busy_cnt = 0;
        reset = 1'b1;
        start = 1'b0;
        a_in  = '0;
        m_in  = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_inverse", 64'(inverse), 64'd0);
        check("reset_gcd", 64'(gcd_out), 64'd0);
        reset = 1'b0;

        // directed vectors: a, m, inverse, gcd, valid, latency
        run_one(40'd3,    40'd11,   40'd4,    40'd1,  1'b1, 4);
        run_one(40'd6,    40'd9,    40'd0,    40'd3,  1'b0, 3);
        run_one(40'd20,   40'd7,    40'd6,    40'd1,  1'b1, 3);
        run_one(40'd0,    40'd7,    40'd0,    40'd7,  1'b0, 1);
        run_one(40'd5,    40'd0,    40'd0,    40'd5,  1'b0, 1);
        run_one(40'd9,    40'd1,    40'd0,    40'd1,  1'b1, 1);
        run_one(40'd17,   40'd3120, 40'd2753, 40'd1,  1'b1, 5);
        run_one(40'd12,   40'd18,   40'd0,    40'd6,  1'b0, 3);
        run_one(M_PRIME - 40'd1, M_PRIME, M_PRIME - 40'd1, 40'd1, 1'b1, 0);

        // start while busy is ignored
        push_exp(40'd4, 40'd1, 1'b1, 4);
        pulse_start(40'd3, 40'd11);
        @(negedge clk);
        a_in  = 40'd6;
        m_in  = 40'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // start held across Ef (ignored) and the following edge (accepted)
        push_exp(40'd4, 40'd1, 1'b1, 4);
        push_exp(40'd6, 40'd1, 1'b1, 3);
        pulse_start(40'd3, 40'd11);
        repeat (3) @(negedge clk);
        a_in  = 40'd20;
        m_in  = 40'd7;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // mid-run reset: no done, outputs cleared
        pulse_start(40'd3, 40'd11);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_valid", 64'(valid), 64'd0);
        check("midreset_inverse", 64'(inverse), 64'd0);
        check("midreset_gcd", 64'(gcd_out), 64'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        run_one(40'd3, 40'd11, 40'd4, 40'd1, 1'b1, 4);

        // prime modulus sweep, expected inverse = a^(m-2) mod m
        for (int i = 0; i < 150; i++) begin
            rnd = {$urandom, $urandom};
            ra  = W'(rnd % 64'(M_PRIME - 40'd1)) + 40'd1;
            run_one(ra, M_PRIME, modpow(ra, M_PRIME - 40'd2, M_PRIME), 40'd1, 1'b1, 0);
        end

        repeat (4) @(negedge clk);
        check("pending_results", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
